// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared types and constants for the reorder buffer slice.
//   status_t    : per-entry lifecycle (empty -> wait -> done -> empty)
//   types_t     : coarse instruction class captured at dispatch
//   rob_entry_t : one ROB slot; grows RVFI monitor fields when ROB_RVFI_EN
//                 is defined
//   WB_*        : writeback unit numbering, matching bit order of wb_valid
// ---------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = 5;
  localparam int WB_UNITS  = 4;

  localparam int WB_ALU = 0;
  localparam int WB_MUL = 1;
  localparam int WB_BR  = 2;
  localparam int WB_MEM = 3;

  typedef enum logic [1:0] {
    ROB_EMPTY = 2'd0,
    ROB_WAIT  = 2'd1,
    ROB_DONE  = 2'd2
  } status_t;

  typedef enum logic [2:0] {
    OP_ALU  = 3'd0,
    OP_MUL  = 3'd1,
    OP_BR   = 3'd2,
    OP_MEM  = 3'd3,
    OP_NONE = 3'd4
  } types_t;

  typedef struct packed {
    status_t     status;
    types_t      op_type;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rd_data;
    logic        br_en;
    logic [31:0] pc_new;
`ifdef ROB_RVFI_EN
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
`endif
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// rob_ptr_ctrl
// Head/tail pointers for the reorder buffer. Pointers carry one extra MSB
// (wrap bit) so full and empty can be told apart when the index bits match.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push         : dispatch accepted this cycle (tail advances)
//   pop          : head retires this cycle (head advances)
//   flush        : head retires and every younger entry is discarded
//   head, tail   : IDX_W+1 bit pointers, MSB is the wrap bit
//   full, empty  : occupancy flags derived from the pointers
// ---------------------------------------------------------------------------
module rob_ptr_ctrl
  import reorder_buffer_pkg::*;
#(
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  output logic [IDX_W:0] head,
  output logic [IDX_W:0] tail,
  output logic           full,
  output logic           empty
);

  logic [IDX_W:0] head_next;

  assign head_next = head + 1'b1;

  assign full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign empty = (head == tail);

  // On a flush the head retires and the queue collapses to empty just past it,
  // so the next dispatch lands in the slot after the redirecting branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= head_next;
      tail <= head_next;
    end else begin
      if (pop)  head <= head_next;
      if (push) tail <= tail + 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Circular in-order retirement queue. Dispatch allocates at the tail and is
// handed the tail index as its tag; functional units mark entries done over
// four writeback lanes (alu, mul, br, mem); the head retires one completed
// entry per cycle and raises flush when it is a taken branch.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   dispatch_*             : allocate request and captured fields; ready/idx out
//   wb_valid/rob_idx/data  : per-unit writeback lanes, bit k = unit k
//   br_en, br_pc_new       : branch outcome, qualified by wb_valid[WB_BR]
//   wb_rvfi_*              : mem-unit monitor data (stored only with ROB_RVFI_EN)
//   commit_*               : retiring entry, all zero when commit_valid is low
//   flush, flush_pc        : redirect pulse and target
// Configuration: define ROB_RVFI_EN to store and export the RVFI monitor
// fields; otherwise the monitor outputs are tied to zero.
// ---------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  input  logic [4:0]             dispatch_rd_addr,
  input  logic                   dispatch_regf_we,
  input  logic [2:0]             dispatch_op_type,
  input  logic [31:0]            dispatch_pc,
  input  logic [31:0]            dispatch_inst,
  output logic                   dispatch_ready,
  output logic [IDX_W-1:0]       dispatch_rob_idx,
  input  logic [WB_UNITS-1:0]    wb_valid,
  input  logic [WB_UNITS*IDX_W-1:0] wb_rob_idx,
  input  logic [WB_UNITS*32-1:0] wb_data,
  input  logic                   br_en,
  input  logic [31:0]            br_pc_new,
  input  logic [4:0]             wb_rvfi_rs1_addr,
  input  logic [4:0]             wb_rvfi_rs2_addr,
  input  logic [31:0]            wb_rvfi_rs1_data,
  input  logic [31:0]            wb_rvfi_rs2_data,
  input  logic [31:0]            wb_rvfi_mem_addr,
  input  logic [3:0]             wb_rvfi_mem_rmask,
  input  logic [3:0]             wb_rvfi_mem_wmask,
  input  logic [31:0]            wb_rvfi_mem_rdata,
  input  logic [31:0]            wb_rvfi_mem_wdata,
  output logic                   commit_valid,
  output logic [IDX_W-1:0]       commit_rob_idx,
  output logic [4:0]             commit_rd_addr,
  output logic [31:0]            commit_rd_data,
  output logic                   commit_regf_we,
  output logic [31:0]            commit_pc,
  output logic [31:0]            commit_inst,
  output logic [4:0]             commit_rs1_addr,
  output logic [4:0]             commit_rs2_addr,
  output logic [31:0]            commit_rs1_data,
  output logic [31:0]            commit_rs2_data,
  output logic [31:0]            commit_mem_addr,
  output logic [3:0]             commit_mem_rmask,
  output logic [3:0]             commit_mem_wmask,
  output logic [31:0]            commit_mem_rdata,
  output logic [31:0]            commit_mem_wdata,
  output logic                   flush,
  output logic [31:0]            flush_pc
);

  rob_entry_t     entries [DEPTH];
  rob_entry_t     head_entry;
  logic [IDX_W:0] head;
  logic [IDX_W:0] tail;
  logic           full;
  logic           empty;
  logic           dispatch_fire;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic           wb_conflict;

  rob_ptr_ctrl #(.IDX_W(IDX_W)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .push  (dispatch_fire),
    .pop   (commit_valid),
    .flush (flush),
    .head  (head),
    .tail  (tail),
    .full  (full),
    .empty (empty)
  );

  assign head_idx   = head[IDX_W-1:0];
  assign tail_idx   = tail[IDX_W-1:0];
  assign head_entry = entries[head_idx];

  // Readiness uses pre-commit occupancy; a full queue stays closed even while
  // its head is retiring, and a flushing cycle never allocates.
  assign dispatch_ready   = !full && !flush;
  assign dispatch_rob_idx = tail_idx;
  assign dispatch_fire    = dispatch_valid && dispatch_ready;

  assign commit_valid   = !empty && (head_entry.status == ROB_DONE);
  assign commit_rob_idx = commit_valid ? head_idx : '0;
  assign commit_rd_addr = commit_valid ? head_entry.rd_addr : '0;
  assign commit_rd_data = commit_valid ? head_entry.rd_data : '0;
  assign commit_regf_we = commit_valid && head_entry.regf_we && (head_entry.rd_addr != 5'd0);
  assign commit_pc      = commit_valid ? head_entry.pc : '0;
  assign commit_inst    = commit_valid ? head_entry.inst : '0;
  assign flush          = commit_valid && head_entry.br_en;
  assign flush_pc       = flush ? head_entry.pc_new : '0;

`ifdef ROB_RVFI_EN
  assign commit_rs1_addr  = commit_valid ? head_entry.rs1_addr  : '0;
  assign commit_rs2_addr  = commit_valid ? head_entry.rs2_addr  : '0;
  assign commit_rs1_data  = commit_valid ? head_entry.rs1_data  : '0;
  assign commit_rs2_data  = commit_valid ? head_entry.rs2_data  : '0;
  assign commit_mem_addr  = commit_valid ? head_entry.mem_addr  : '0;
  assign commit_mem_rmask = commit_valid ? head_entry.mem_rmask : '0;
  assign commit_mem_wmask = commit_valid ? head_entry.mem_wmask : '0;
  assign commit_mem_rdata = commit_valid ? head_entry.mem_rdata : '0;
  assign commit_mem_wdata = commit_valid ? head_entry.mem_wdata : '0;
`else
  logic unused_rvfi;
  assign unused_rvfi = ^{wb_rvfi_rs1_addr, wb_rvfi_rs2_addr, wb_rvfi_rs1_data,
                         wb_rvfi_rs2_data, wb_rvfi_mem_addr, wb_rvfi_mem_rmask,
                         wb_rvfi_mem_wmask, wb_rvfi_mem_rdata, wb_rvfi_mem_wdata};
  assign commit_rs1_addr  = '0;
  assign commit_rs2_addr  = '0;
  assign commit_rs1_data  = '0;
  assign commit_rs2_data  = '0;
  assign commit_mem_addr  = '0;
  assign commit_mem_rmask = '0;
  assign commit_mem_wmask = '0;
  assign commit_mem_rdata = '0;
  assign commit_mem_wdata = '0;
`endif

  // The class tag travels with the entry for downstream consumers but is not
  // needed to retire it.
  logic unused_head;
  assign unused_head = ^head_entry.op_type;

  // Entry state. Writeback only lands on an entry still waiting, so stale or
  // duplicate completions are dropped. While not full the tail slot is empty
  // and distinct from the head, so dispatch, writeback and commit never touch
  // the same field in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].status <= ROB_EMPTY;
    end else begin
      if (commit_valid) entries[head_idx].status <= ROB_EMPTY;
      for (int k = 0; k < WB_UNITS; k++) begin
        if (wb_valid[k] && (entries[wb_rob_idx[k*IDX_W +: IDX_W]].status == ROB_WAIT)) begin
          entries[wb_rob_idx[k*IDX_W +: IDX_W]].status  <= ROB_DONE;
          entries[wb_rob_idx[k*IDX_W +: IDX_W]].rd_data <= wb_data[k*32 +: 32];
          if (k == WB_BR) begin
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].br_en  <= br_en;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].pc_new <= br_pc_new;
          end
`ifdef ROB_RVFI_EN
          if (k == WB_MEM) begin
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].rs1_addr  <= wb_rvfi_rs1_addr;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].rs2_addr  <= wb_rvfi_rs2_addr;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].rs1_data  <= wb_rvfi_rs1_data;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].rs2_data  <= wb_rvfi_rs2_data;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].mem_addr  <= wb_rvfi_mem_addr;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].mem_rmask <= wb_rvfi_mem_rmask;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].mem_wmask <= wb_rvfi_mem_wmask;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].mem_rdata <= wb_rvfi_mem_rdata;
            entries[wb_rob_idx[k*IDX_W +: IDX_W]].mem_wdata <= wb_rvfi_mem_wdata;
          end
`endif
        end
      end
      if (dispatch_fire) begin
        entries[tail_idx]         <= '0;
        entries[tail_idx].status  <= ROB_WAIT;
        entries[tail_idx].op_type <= types_t'(dispatch_op_type);
        entries[tail_idx].rd_addr <= dispatch_rd_addr;
        entries[tail_idx].regf_we <= dispatch_regf_we;
        entries[tail_idx].pc      <= dispatch_pc;
        entries[tail_idx].inst    <= dispatch_inst;
      end
    end
  end

  // Two units completing the same tag in one cycle is an upstream bug.
  always_comb begin
    wb_conflict = 1'b0;
    for (int a = 0; a < WB_UNITS; a++) begin
      for (int b = a + 1; b < WB_UNITS; b++) begin
        if (wb_valid[a] && wb_valid[b] &&
            (wb_rob_idx[a*IDX_W +: IDX_W] == wb_rob_idx[b*IDX_W +: IDX_W]))
          wb_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!wb_conflict);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
// Directed test of the reorder buffer: single-entry round trip, out-of-order
// completion with in-order retire, full/wrap behaviour, branch flush, x0
// writes and stale writebacks, and reset with work in flight.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic         clk;
  logic         rst;
  logic         dispatch_valid;
  logic [4:0]   dispatch_rd_addr;
  logic         dispatch_regf_we;
  logic [2:0]   dispatch_op_type;
  logic [31:0]  dispatch_pc;
  logic [31:0]  dispatch_inst;
  logic         dispatch_ready;
  logic [4:0]   dispatch_rob_idx;
  logic [3:0]   wb_valid;
  logic [19:0]  wb_rob_idx;
  logic [127:0] wb_data;
  logic         br_en;
  logic [31:0]  br_pc_new;
  logic         commit_valid;
  logic [4:0]   commit_rob_idx;
  logic [4:0]   commit_rd_addr;
  logic [31:0]  commit_rd_data;
  logic         commit_regf_we;
  logic [31:0]  commit_pc;
  logic [31:0]  commit_inst;
  logic [4:0]   commit_rs1_addr;
  logic [4:0]   commit_rs2_addr;
  logic [31:0]  commit_rs1_data;
  logic [31:0]  commit_rs2_data;
  logic [31:0]  commit_mem_addr;
  logic [3:0]   commit_mem_rmask;
  logic [3:0]   commit_mem_wmask;
  logic [31:0]  commit_mem_rdata;
  logic [31:0]  commit_mem_wdata;
  logic         flush;
  logic [31:0]  flush_pc;

  int assertCount = 0;
  int failCount   = 0;

  reorder_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .dispatch_valid    (dispatch_valid),
    .dispatch_rd_addr  (dispatch_rd_addr),
    .dispatch_regf_we  (dispatch_regf_we),
    .dispatch_op_type  (dispatch_op_type),
    .dispatch_pc       (dispatch_pc),
    .dispatch_inst     (dispatch_inst),
    .dispatch_ready    (dispatch_ready),
    .dispatch_rob_idx  (dispatch_rob_idx),
    .wb_valid          (wb_valid),
    .wb_rob_idx        (wb_rob_idx),
    .wb_data           (wb_data),
    .br_en             (br_en),
    .br_pc_new         (br_pc_new),
    .wb_rvfi_rs1_addr  (5'd0),
    .wb_rvfi_rs2_addr  (5'd0),
    .wb_rvfi_rs1_data  (32'd0),
    .wb_rvfi_rs2_data  (32'd0),
    .wb_rvfi_mem_addr  (32'd0),
    .wb_rvfi_mem_rmask (4'd0),
    .wb_rvfi_mem_wmask (4'd0),
    .wb_rvfi_mem_rdata (32'd0),
    .wb_rvfi_mem_wdata (32'd0),
    .commit_valid      (commit_valid),
    .commit_rob_idx    (commit_rob_idx),
    .commit_rd_addr    (commit_rd_addr),
    .commit_rd_data    (commit_rd_data),
    .commit_regf_we    (commit_regf_we),
    .commit_pc         (commit_pc),
    .commit_inst       (commit_inst),
    .commit_rs1_addr   (commit_rs1_addr),
    .commit_rs2_addr   (commit_rs2_addr),
    .commit_rs1_data   (commit_rs1_data),
    .commit_rs2_data   (commit_rs2_data),
    .commit_mem_addr   (commit_mem_addr),
    .commit_mem_rmask  (commit_mem_rmask),
    .commit_mem_wmask  (commit_mem_wmask),
    .commit_mem_rdata  (commit_mem_rdata),
    .commit_mem_wdata  (commit_mem_wdata),
    .flush             (flush),
    .flush_pc          (flush_pc)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance past one rising edge; inputs are driven and outputs sampled 2
  // time units later, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive the dispatch port.
  task automatic applyStimulus(input logic valid, input logic [4:0] rd, input logic we,
                               input logic [2:0] op, input logic [31:0] pc);
    dispatch_valid   = valid;
    dispatch_rd_addr = rd;
    dispatch_regf_we = we;
    dispatch_op_type = op;
    dispatch_pc      = pc;
    dispatch_inst    = pc ^ 32'h0000_0013;
  endtask

  task automatic setWb(input int unit, input logic [4:0] idx, input logic [31:0] data);
    wb_valid[unit]             = 1'b1;
    wb_rob_idx[unit*5 +: 5]    = idx;
    wb_data[unit*32 +: 32]     = data;
  endtask

  task automatic clearWb();
    wb_valid   = '0;
    wb_rob_idx = '0;
    wb_data    = '0;
    br_en      = 1'b0;
    br_pc_new  = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    clearWb();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    clearWb();

    // ---- single entry round trip and reset state ----
    doReset();
    checkOutput("rst_commit_valid", 32'(commit_valid), 32'd0);
    checkOutput("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    checkOutput("rst_dispatch_idx", 32'(dispatch_rob_idx), 32'd0);
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_flush_pc", flush_pc, 32'd0);
    checkOutput("rst_commit_rd_data", commit_rd_data, 32'd0);
    applyStimulus(1'b1, 5'd5, 1'b1, 3'(OP_ALU), 32'h1000);
    checkOutput("t1_dispatch_idx", 32'(dispatch_rob_idx), 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    setWb(WB_ALU, 5'd0, 32'h2A);
    checkOutput("t1_not_done_yet", 32'(commit_valid), 32'd0);
    checkOutput("t1_next_idx", 32'(dispatch_rob_idx), 32'd1);
    tick();
    clearWb();
    checkOutput("t1_commit_valid", 32'(commit_valid), 32'd1);
    checkOutput("t1_commit_idx", 32'(commit_rob_idx), 32'd0);
    checkOutput("t1_commit_rd", 32'(commit_rd_addr), 32'd5);
    checkOutput("t1_commit_data", commit_rd_data, 32'h2A);
    checkOutput("t1_commit_we", 32'(commit_regf_we), 32'd1);
    checkOutput("t1_commit_pc", commit_pc, 32'h1000);
    checkOutput("t1_commit_inst", commit_inst, 32'h1013);
    checkOutput("t1_no_flush", 32'(flush), 32'd0);
    tick();
    checkOutput("t1_drained", 32'(commit_valid), 32'd0);

    // ---- out-of-order completion, in-order retire ----
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 1'b1, 3'(OP_ALU), 32'h100 + 32'(4 * i));
      checkOutput("t2_dispatch_idx", 32'(dispatch_rob_idx), 32'(i));
      tick();
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    setWb(WB_MUL, 5'd2, 32'h22);
    tick();
    clearWb();
    checkOutput("t2_idx2_done_head_blocked", 32'(commit_valid), 32'd0);
    setWb(WB_ALU, 5'd0, 32'h11);
    tick();
    clearWb();
    checkOutput("t2_commit0_valid", 32'(commit_valid), 32'd1);
    checkOutput("t2_commit0_idx", 32'(commit_rob_idx), 32'd0);
    checkOutput("t2_commit0_data", commit_rd_data, 32'h11);
    setWb(WB_MEM, 5'd1, 32'h33);
    tick();
    clearWb();
    checkOutput("t2_commit1_valid", 32'(commit_valid), 32'd1);
    checkOutput("t2_commit1_idx", 32'(commit_rob_idx), 32'd1);
    checkOutput("t2_commit1_data", commit_rd_data, 32'h33);
    tick();
    checkOutput("t2_commit2_valid", 32'(commit_valid), 32'd1);
    checkOutput("t2_commit2_idx", 32'(commit_rob_idx), 32'd2);
    checkOutput("t2_commit2_rd", 32'(commit_rd_addr), 32'd3);
    checkOutput("t2_commit2_data", commit_rd_data, 32'h22);
    tick();
    checkOutput("t2_drained", 32'(commit_valid), 32'd0);

    // ---- fill, full rejection during commit, wrap-around ----
    doReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 5'd1, 1'b1, 3'(OP_ALU), 32'h4000 + 32'(4 * i));
      checkOutput("t3_fill_idx", 32'(dispatch_rob_idx), 32'(i));
      tick();
    end
    checkOutput("t3_full_not_ready", 32'(dispatch_ready), 32'd0);
    setWb(WB_ALU, 5'd0, 32'h55);
    tick();
    clearWb();
    checkOutput("t3_head_commit_valid", 32'(commit_valid), 32'd1);
    checkOutput("t3_head_commit_idx", 32'(commit_rob_idx), 32'd0);
    checkOutput("t3_full_while_commit", 32'(dispatch_ready), 32'd0);
    tick();
    checkOutput("t3_ready_after_commit", 32'(dispatch_ready), 32'd1);
    checkOutput("t3_wrapped_idx", 32'(dispatch_rob_idx), 32'd0);
    checkOutput("t3_tail_wrap", 32'(dut.u_ptr.tail), 32'd32);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    checkOutput("t3_accepted_idx", 32'(dispatch_rob_idx), 32'd1);
    checkOutput("t3_tail_after", 32'(dut.u_ptr.tail), 32'd33);
    checkOutput("t3_full_again", 32'(dispatch_ready), 32'd0);

    // ---- branch redirect flush ----
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 1'b1, (i == 4) ? 3'(OP_BR) : 3'(OP_ALU), 32'h1000 + 32'(4 * i));
      tick();
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    setWb(WB_ALU, 5'd0, 32'hA0);
    setWb(WB_MUL, 5'd1, 32'hA1);
    setWb(WB_BR,  5'd3, 32'hA3);
    setWb(WB_MEM, 5'd2, 32'hA2);
    tick();
    clearWb();
    checkOutput("t4_commit0_valid", 32'(commit_valid), 32'd1);
    setWb(WB_BR,  5'd4, 32'hB4);
    br_en     = 1'b1;
    br_pc_new = 32'h2000;
    setWb(WB_ALU, 5'd5, 32'hB5);
    setWb(WB_MUL, 5'd6, 32'hB6);
    tick();
    clearWb();
    for (int j = 1; j < 4; j++) begin
      checkOutput("t4_commit_idx", 32'(commit_rob_idx), 32'(j));
      checkOutput("t4_no_early_flush", 32'(flush), 32'd0);
      tick();
    end
    checkOutput("t4_br_commit_valid", 32'(commit_valid), 32'd1);
    checkOutput("t4_br_commit_idx", 32'(commit_rob_idx), 32'd4);
    checkOutput("t4_br_commit_data", commit_rd_data, 32'hB4);
    checkOutput("t4_flush", 32'(flush), 32'd1);
    checkOutput("t4_flush_pc", flush_pc, 32'h2000);
    checkOutput("t4_no_dispatch_on_flush", 32'(dispatch_ready), 32'd0);
    applyStimulus(1'b1, 5'd9, 1'b1, 3'(OP_ALU), 32'h3000);
    setWb(WB_MEM, 5'd7, 32'hC7);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    clearWb();
    checkOutput("t4_younger_squashed", 32'(commit_valid), 32'd0);
    checkOutput("t4_flush_low", 32'(flush), 32'd0);
    checkOutput("t4_flush_pc_low", flush_pc, 32'd0);
    checkOutput("t4_ready_after_flush", 32'(dispatch_ready), 32'd1);
    checkOutput("t4_next_idx", 32'(dispatch_rob_idx), 32'd5);
    setWb(WB_ALU, 5'd5, 32'hD5);
    tick();
    clearWb();
    checkOutput("t4_stale_wb_ignored", 32'(commit_valid), 32'd0);
    applyStimulus(1'b1, 5'd9, 1'b1, 3'(OP_ALU), 32'h2000);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    checkOutput("t4_new_entry_waits", 32'(commit_valid), 32'd0);
    checkOutput("t4_new_tail", 32'(dispatch_rob_idx), 32'd6);

    // ---- x0 destination and writeback to an empty slot ----
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b1, 3'(OP_ALU), 32'h500);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    setWb(WB_ALU, 5'd5, 32'h99);
    tick();
    clearWb();
    checkOutput("t5_empty_wb_no_commit", 32'(commit_valid), 32'd0);
    checkOutput("t5_empty_wb_tail", 32'(dispatch_rob_idx), 32'd1);
    setWb(WB_ALU, 5'd0, 32'h77);
    tick();
    clearWb();
    checkOutput("t5_x0_commit_valid", 32'(commit_valid), 32'd1);
    checkOutput("t5_x0_regf_we", 32'(commit_regf_we), 32'd0);
    checkOutput("t5_x0_data", commit_rd_data, 32'h77);

    // ---- reset with work in flight ----
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'd7, 1'b1, 3'(OP_ALU), 32'h600 + 32'(4 * i));
      tick();
    end
    setWb(WB_ALU, 5'd0, 32'hE0);
    setWb(WB_MUL, 5'd1, 32'hE1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    clearWb();
    checkOutput("t6_commit_valid", 32'(commit_valid), 32'd0);
    checkOutput("t6_dispatch_idx", 32'(dispatch_rob_idx), 32'd0);
    checkOutput("t6_dispatch_ready", 32'(dispatch_ready), 32'd1);
    tick();
    checkOutput("t6_still_idle", 32'(commit_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue between dispatch and architectural commit in the out-of-order RV32I core.
- Dispatch allocates one entry per cycle and receives its ROB index (the tag used by the RAT and reservation stations).
- Functional units mark entries done via the CDB writeback fields.
- The head retires one entry per cycle to the RAT/ARF and raises flush on a taken-branch redirect.

Parameters:
- DEPTH, 32, entry count; power of two.
- IDX_W, 5, log2(DEPTH); matches rob_idx width in the shared types.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (already decided)
- dispatch_valid  in  1  allocate request
- dispatch_rd_addr  in  5  destination arch register
- dispatch_regf_we  in  1  instruction writes rd
- dispatch_op_type  in  3  types_t (alu/mul/br/mem/none)
- dispatch_pc  in  32  instruction PC
- dispatch_inst  in  32  instruction word
- dispatch_ready  out  1  entry available this cycle
- dispatch_rob_idx  out  IDX_W  index granted (current tail)
- wb_valid  in  4  writeback strobes; bit0 alu, 1 mul, 2 br, 3 mem
- wb_rob_idx  in  4*IDX_W  per-unit target index, same bit order
- wb_data  in  4*32  per-unit rd result
- br_en  in  1  branch redirect, qualified by wb_valid[2]
- br_pc_new  in  32  redirect target, qualified by wb_valid[2]
- commit_valid  out  1  head retires this cycle
- commit_rob_idx  out  IDX_W  retiring index
- commit_rd_addr  out  5  retiring rd
- commit_rd_data  out  32  retiring result
- commit_regf_we  out  1  write ARF; 0 if rd_addr==0
- commit_pc  out  32  retiring PC
- commit_inst  out  32  retiring instruction word
- flush  out  1  pipeline flush pulse
- flush_pc  out  32  fetch redirect target

Behaviour:
Storage and pointers:
- Array of rob_entry_t.
- head/tail pointers are IDX_W+1 bits; the MSB is the wrap bit.
- full = (index bits equal) and (wrap bits differ).
- empty = head == tail.

Reset:
- Every entry status=empty; head=tail=0.
- All outputs 0 except dispatch_ready=1.
- Reset asserted mid-operation discards all contents on that edge, including any same-cycle dispatch or writeback.

Dispatch:
- dispatch_ready = !full && !flush. It uses pre-commit occupancy: a full ROB rejects dispatch even when committing in the same cycle.
- dispatch_rob_idx = tail[IDX_W-1:0], valid combinationally.
- On accept (valid && ready): entry status=rob_wait; fields and br_en=0 captured; tail+1 on the edge.

Writeback:
- For each set wb_valid[k] whose target entry is rob_wait: at the edge, status=done and rd_data captured.
- Unit 2 also captures br_en and pc_new.
- A writeback to an entry that is empty or already done is ignored.
- Two units writing the same index in one cycle is illegal (assertion).

Commit:
- Combinational from head: commit_valid = head status==done.
- On that edge, the entry goes to empty and head+1.
- Writeback at edge N makes commit_valid high in the cycle after N. There is no same-cycle writeback-to-commit bypass; minimum completion-to-retire latency is 1 cycle.
- Throughput: 1 retire/cycle.

Flush:
- flush = commit_valid && head br_en; flush_pc = head pc_new.
- On that edge the head entry retires normally (commit_* valid).
- All other entries go to empty; tail=head+1 (new head); same-cycle dispatch is dropped; same-cycle writebacks are dropped.
- When flush is low, flush_pc = 0.

Wrap-around:
- Pointer increments are modulo 2*DEPTH.
- Index DEPTH-1 is followed by index 0 with the wrap bit toggled.

Simultaneous events:
- Dispatch, writeback and commit in the same cycle are all honoured.
- An empty ROB accepts dispatch and cannot commit that cycle.

Optional Feature:
- Macro: ROB_RVFI_EN.
- Defined: entries also store rs1/rs2 addr and data plus mem_addr/rmask/wmask/rdata/wdata. These are written from a unit-3 writeback extension and exported on matching commit_* monitor ports, valid with commit_valid.
- Undefined: those fields are not stored; monitor ports are driven 0.
- Core behaviour and timing are identical either way.

Decomposition:
- Shared package holds:
  - status_t, types_t and rob_entry_t (extended with RVFI fields under the macro).
  - ROB_DEPTH and ROB_IDX_W constants.
  - Writeback unit-index constants WB_ALU=0, WB_MUL=1, WB_BR=2, WB_MEM=3.
- One natural sub-module: rob_ptr_ctrl, holding head/tail with wrap bits, full/empty, and the increment/flush-reset logic.

Test Plan:
- Reset then dispatch pc=0x1000, rd=x5 → dispatch_rob_idx=0. Next cycle wb_valid[0], idx 0, data 0x2A → the following cycle commit_valid=1, rd=5, data=0x2A, regf_we=1.
- Dispatch 3 entries (idx 0,1,2), writeback order 2,0,1 → commits occur in order 0,1,2 on consecutive cycles once idx1 completes.
- Fill 32 entries → dispatch_ready=0. Complete idx0 and hold dispatch_valid → idx0 commits and dispatch is rejected that cycle; accepted next cycle with dispatch_rob_idx=0 and wrap bit set.
- Dispatch br at idx4 plus 3 younger entries; unit 2 writes idx4 with br_en=1, pc_new=0x2000 → when idx4 retires, flush=1 and flush_pc=0x2000. Next dispatch receives idx5; younger entries never commit.
- Dispatch with rd=x0, regf_we=1 → commit_regf_we=0. A writeback to an empty index has no effect (no commit).
- Assert rst while 10 entries are in flight with writebacks pending → next cycle commit_valid=0, dispatch_rob_idx=0, dispatch_ready=1.
